branch_exec_q: RTL and testbench

Parametrised branch/jump execution unit for the out-of-order core; successor to the single-slot branch executor. It resolves BRANCH/JAL/JALR ops issued from the branch reservation station and queues results in a DEPTH-entry FIFO for CDB arbitration. It also compares each outcome against the fetch-time prediction, raising a one-cycle redirect on mispredict, and supports pipeline flush plus saturating performance counters.

---
 rtl/branch_exec_q_pkg.sv | 32 +++
 rtl/branch_exec_q_branch_unit.sv | 54 +++++
 rtl/branch_exec_q.sv | 187 ++++++++++++++++++
 tb/tb_branch_exec_q.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_exec_q_pkg.sv
// Shared types for the branch execution queue and its compare/target unit.
package branch_exec_q_pkg;

    // Compare operation, encoded like the RISC-V branch funct3 field
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_op_t;

    // Kind of control op arriving from the branch reservation station
    typedef enum logic [1:0] {
        ITYPE_BRANCH = 2'b00,
        ITYPE_JAL    = 2'b01,
        ITYPE_JALR   = 2'b10,
        ITYPE_OTHER  = 2'b11
    } inst_type_t;

    localparam int RESOLVE_XLEN  = 32;
    localparam int RESOLVE_ROB_W = 5;

    // Redirect record as seen by front-end consumers (fetch / ROB recovery)
    typedef struct packed {
        logic                     valid;
        logic [RESOLVE_XLEN-1:0]  pc;
        logic [RESOLVE_ROB_W-1:0] rob_id;
    } branch_resolve_t;

endpackage

// File: rtl/branch_exec_q_branch_unit.sv
// Combinational branch resolver: direction compare and next-PC target.
// The core has no compressed instructions, so JALR targets are word aligned.
module branch_unit
    import branch_exec_q_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  branch_op_t      op,
    input  inst_type_t      inst_type,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            taken,
    output logic [XLEN-1:0] target
);

    logic [XLEN-1:0] jalr_sum;

    assign jalr_sum = rs1 + imm;

    // Resolve direction and target for the op type presented this cycle
    always_comb begin
        taken  = 1'b0;
        target = '0;
        case (inst_type)
            ITYPE_BRANCH: begin
                target = pc + imm;
                case (op)
                    BR_BEQ:  taken = (rs1 == rs2);
                    BR_BNE:  taken = (rs1 != rs2);
                    BR_BLT:  taken = ($signed(rs1) < $signed(rs2));
                    BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
                    BR_BLTU: taken = (rs1 < rs2);
                    BR_BGEU: taken = (rs1 >= rs2);
                    default: taken = 1'b0;
                endcase
            end
            ITYPE_JAL: begin
                taken  = 1'b1;
                target = pc + imm;
            end
            ITYPE_JALR: begin
                taken  = 1'b1;
                target = jalr_sum & ~XLEN'(3);
            end
            default: begin
                taken  = 1'b0;
                target = '0;
            end
        endcase
    end

endmodule

// File: rtl/branch_exec_q.sv
// Branch/jump execution unit with an in-order result FIFO feeding CDB
// arbitration, mispredict redirect generation and saturating perf counters.
module branch_exec_q
    import branch_exec_q_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  branch_op_t        branch_op,
    input  inst_type_t        inst_type,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic              pred_taken,
    input  logic [XLEN-1:0]   pred_target,
    input  logic [PREG_W-1:0] dest_preg,
    input  logic [ROB_W-1:0]  rob_id,
    input  logic              flush,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic              cdb_valid,
    output logic [PREG_W-1:0] cdb_preg,
    output logic [XLEN-1:0]   cdb_data,
    output logic [ROB_W-1:0]  cdb_rob_id,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [ROB_W-1:0]  redirect_rob_id,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mispred_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [XLEN-1:0]   mem_data [DEPTH];
    logic [PREG_W-1:0] mem_preg [DEPTH];
    logic [ROB_W-1:0]  mem_rob  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occupancy;

    logic              full;
    logic              push;
    logic              pop;
    logic [XLEN-1:0]   rs1_gated;
    logic [XLEN-1:0]   rs2_gated;
    logic              taken;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   entry_data;
    logic              mispredict;

    assign full      = (occupancy == FULL_OCC);
    assign cdb_req   = (occupancy != '0);
    assign pop       = cdb_req & cdb_grant & ~flush;
    assign ready_out = ~full | pop;
    assign push      = valid_in & ready_out & ~flush;

    assign rs1_gated = valid_in ? rs1_data : '0;
    assign rs2_gated = valid_in ? rs2_data : '0;
    assign pc_plus4  = pc + XLEN'(4);

    branch_unit #(
        .XLEN (XLEN)
    ) u_branch_unit (
        .rs1       (rs1_gated),
        .rs2       (rs2_gated),
        .op        (branch_op),
        .inst_type (inst_type),
        .pc        (pc),
        .imm       (imm),
        .taken     (taken),
        .target    (target)
    );

    // Pick the value written back to the destination register for this op
    always_comb begin
        entry_data = '0;
        mispredict = 1'b0;
        case (inst_type)
            ITYPE_BRANCH: begin
                entry_data = {target[XLEN-1:1], taken};
                mispredict = (taken != pred_taken) | (taken & (target != pred_target));
            end
            ITYPE_JAL, ITYPE_JALR: begin
                entry_data = pc_plus4;
                mispredict = ~pred_taken | (target != pred_target);
            end
            default: begin
                entry_data = '0;
                mispredict = 1'b0;
            end
        endcase
    end

    // Result storage; only the pointers and occupancy need a reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= entry_data;
            mem_preg[wr_ptr] <= dest_preg;
            mem_rob[wr_ptr]  <= rob_id;
        end
    end

    // FIFO pointers and occupancy, cleared by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (pop && !push) begin
                occupancy <= occupancy - OCC_W'(1);
            end
        end
    end

    // Move the FIFO head onto the CDB when the arbiter grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid  <= 1'b0;
            cdb_preg   <= '0;
            cdb_data   <= '0;
            cdb_rob_id <= '0;
        end else begin
            cdb_valid <= pop;
            if (pop) begin
                cdb_preg   <= mem_preg[rd_ptr];
                cdb_data   <= mem_data[rd_ptr];
                cdb_rob_id <= mem_rob[rd_ptr];
            end
        end
    end

    // One-cycle redirect pulse for every accepted mispredict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
            redirect_rob_id <= '0;
        end else begin
            redirect_valid <= push & mispredict;
            if (push && mispredict) begin
                redirect_pc     <= taken ? target : pc_plus4;
                redirect_rob_id <= rob_id;
            end
        end
    end

    // Saturating counts of resolved control ops and of mispredicts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (push && (br_count != '1)) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (push && mispredict && (mispred_count != '1)) begin
                mispred_count <= mispred_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_exec_q.sv
// Scoreboard bench for branch_exec_q: directed ops push hand-computed CDB and
// redirect expectations; a monitor pops and compares whenever the DUT presents them.
module tb_branch_exec_q;
    import branch_exec_q_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    typedef struct packed {
        logic [5:0]  preg;
        logic [31:0] data;
        logic [4:0]  rob;
    } cdb_exp_t;

    logic             clk;
    logic             rst_n;
    logic             valid_in;
    logic             ready_out;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    branch_op_t       branch_op;
    inst_type_t       inst_type;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic [5:0]       dest_preg;
    logic [4:0]       rob_id;
    logic             flush;
    logic             cdb_req;
    logic             cdb_grant;
    logic             cdb_valid;
    logic [5:0]       cdb_preg;
    logic [31:0]      cdb_data;
    logic [4:0]       cdb_rob_id;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [4:0]       redirect_rob_id;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    int tests_run;
    int tests_failed;
    int exp_br;
    int exp_mis;
    cdb_exp_t        cdb_q[$];
    branch_resolve_t redir_q[$];

    branch_exec_q #(
        .XLEN   (32),
        .PREG_W (6),
        .ROB_W  (5),
        .DEPTH  (2),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .branch_op       (branch_op),
        .inst_type       (inst_type),
        .pc              (pc),
        .imm             (imm),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .dest_preg       (dest_preg),
        .rob_id          (rob_id),
        .flush           (flush),
        .cdb_req         (cdb_req),
        .cdb_grant       (cdb_grant),
        .cdb_valid       (cdb_valid),
        .cdb_preg        (cdb_preg),
        .cdb_data        (cdb_data),
        .cdb_rob_id      (cdb_rob_id),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .redirect_rob_id (redirect_rob_id),
        .br_count        (br_count),
        .mispred_count   (mispred_count)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveOp(input branch_op_t op, input inst_type_t it,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] p, input logic [31:0] im,
                           input logic pt, input logic [31:0] ptgt,
                           input logic [5:0] preg, input logic [4:0] rob);
        valid_in    = 1'b1;
        branch_op   = op;
        inst_type   = it;
        rs1_data    = r1;
        rs2_data    = r2;
        pc          = p;
        imm         = im;
        pred_taken  = pt;
        pred_target = ptgt;
        dest_preg   = preg;
        rob_id      = rob;
    endtask

    task automatic expectOp(input logic [5:0] preg, input logic [4:0] rob,
                            input logic [31:0] data, input logic mis,
                            input logic [31:0] rpc);
        cdb_exp_t        c;
        branch_resolve_t r;
        c.preg = preg;
        c.data = data;
        c.rob  = rob;
        cdb_q.push_back(c);
        if (exp_br < CNT_MAX) exp_br++;
        if (mis) begin
            r.valid  = 1'b1;
            r.pc     = rpc;
            r.rob_id = rob;
            redir_q.push_back(r);
            if (exp_mis < CNT_MAX) exp_mis++;
        end
    endtask

    // Issue one op, wait (bounded) for ready_out, and return just after the accept edge
    task automatic applyStimulus(input branch_op_t op, input inst_type_t it,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] p, input logic [31:0] im,
                                 input logic pt, input logic [31:0] ptgt,
                                 input logic [5:0] preg, input logic [4:0] rob,
                                 input logic [31:0] exp_data, input logic exp_mis,
                                 input logic [31:0] exp_rpc);
        bit accepted;
        accepted = 1'b0;
        driveOp(op, it, r1, r2, p, im, pt, ptgt, preg, rob);
        for (int k = 0; k < 20 && !accepted; k++) begin
            @(negedge clk);
            if (ready_out) accepted = 1'b1;
            else @(posedge clk);
        end
        if (!accepted) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept_timeout: got ready_out=0, expected 1 within 20 cycles");
        end else begin
            expectOp(preg, rob, exp_data, exp_mis, exp_rpc);
            @(posedge clk);
        end
        #1 valid_in = 1'b0;
    endtask

    task automatic clearScoreboard();
        cdb_q.delete();
        redir_q.delete();
    endtask

    initial begin
        cdb_exp_t        c;
        branch_resolve_t r;

        tests_run    = 0;
        tests_failed = 0;
        exp_br       = 0;
        exp_mis      = 0;
        rst_n        = 1'b0;
        valid_in     = 1'b0;
        rs1_data     = '0;
        rs2_data     = '0;
        branch_op    = BR_BEQ;
        inst_type    = ITYPE_BRANCH;
        pc           = '0;
        imm          = '0;
        pred_taken   = 1'b0;
        pred_target  = '0;
        dest_preg    = '0;
        rob_id       = '0;
        flush        = 1'b0;
        cdb_grant    = 1'b0;

        // Monitor: compare every CDB broadcast and redirect pulse against the scoreboard
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (cdb_valid) begin
                        if (cdb_q.size() == 0) begin
                            tests_run++;
                            tests_failed++;
                            $display("[TB] FAIL cdb_unexpected: got cdb_valid=1 rob=%0d, expected no broadcast", cdb_rob_id);
                        end else begin
                            c = cdb_q.pop_front();
                            checkOutput("cdb_preg", 32'(cdb_preg), 32'(c.preg));
                            checkOutput("cdb_data", cdb_data, c.data);
                            checkOutput("cdb_rob_id", 32'(cdb_rob_id), 32'(c.rob));
                        end
                    end
                    if (redirect_valid) begin
                        if (redir_q.size() == 0) begin
                            tests_run++;
                            tests_failed++;
                            $display("[TB] FAIL redirect_unexpected: got redirect_valid=1 rob=%0d, expected none", redirect_rob_id);
                        end else begin
                            r = redir_q.pop_front();
                            checkOutput("redirect_pc", redirect_pc, r.pc);
                            checkOutput("redirect_rob_id", 32'(redirect_rob_id), 32'(r.rob_id));
                        end
                    end
                end
            end
            begin
                #200000;
                $display("[TB] FAIL watchdog: simulation still running at 200us, expected completion");
                $fatal(1, "[TB] watchdog expired");
            end
        join_none

        // Reset state
        #12;
        checkOutput("rst_ready_out", 32'(ready_out), 32'd1);
        checkOutput("rst_cdb_req", 32'(cdb_req), 32'd0);
        checkOutput("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        checkOutput("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        checkOutput("rst_br_count", 32'(br_count), 32'd0);
        checkOutput("rst_mispred_count", 32'(mispred_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cdb_grant = 1'b1;
        @(posedge clk);
        #1;

        // BEQ taken, correctly predicted: CDB at N+2, no redirect
        applyStimulus(BR_BEQ, ITYPE_BRANCH, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120,
                      6'd7, 5'd3, 32'h121, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("beq_req_n1", 32'(cdb_req), 32'd1);
        checkOutput("beq_valid_n1", 32'(cdb_valid), 32'd0);
        checkOutput("beq_no_redirect", 32'(redirect_valid), 32'd0);
        checkOutput("beq_br_count", 32'(br_count), 32'd1);
        @(negedge clk);
        checkOutput("beq_valid_n2", 32'(cdb_valid), 32'd1);
        @(posedge clk);
        #1;

        // BNE not taken but predicted taken: redirect to pc+4
        applyStimulus(BR_BNE, ITYPE_BRANCH, 32'd9, 32'd9, 32'h200, 32'h10, 1'b1, 32'h210,
                      6'd8, 5'd4, 32'h210, 1'b1, 32'h204);
        @(negedge clk);
        checkOutput("bne_redirect_n1", 32'(redirect_valid), 32'd1);
        checkOutput("bne_mispred_count", 32'(mispred_count), 32'd1);
        @(negedge clk);
        checkOutput("bne_redirect_n2", 32'(redirect_valid), 32'd0);
        @(posedge clk);
        #1;

        // JALR with low address bits cleared, JAL whose link wraps, signed/unsigned compares, non-control op
        applyStimulus(BR_BEQ, ITYPE_JALR, 32'h1003, 32'h0, 32'h40, 32'h0, 1'b1, 32'h1000,
                      6'd9, 5'd5, 32'h44, 1'b0, 32'h0);
        applyStimulus(BR_BEQ, ITYPE_JAL, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h8, 1'b1, 32'h4,
                      6'd10, 5'd6, 32'h0, 1'b0, 32'h0);
        applyStimulus(BR_BLT, ITYPE_BRANCH, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'hFFFF_FFF8, 1'b0, 32'h0,
                      6'd11, 5'd7, 32'h2F9, 1'b1, 32'h2F8);
        applyStimulus(BR_BLTU, ITYPE_BRANCH, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'hFFFF_FFF8, 1'b0, 32'h0,
                      6'd12, 5'd8, 32'h2F8, 1'b0, 32'h0);
        applyStimulus(BR_BEQ, ITYPE_OTHER, 32'h7, 32'h7, 32'h500, 32'h4, 1'b1, 32'h504,
                      6'd13, 5'd9, 32'h0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("mix_br_count", 32'(br_count), 32'd7);
        checkOutput("mix_mispred_count", 32'(mispred_count), 32'd2);

        // Fill the 2-entry FIFO with grant low, then push+pop while full
        @(posedge clk);
        #1 cdb_grant = 1'b0;
        driveOp(BR_BEQ, ITYPE_JAL, 32'h0, 32'h0, 32'h600, 32'h0, 1'b1, 32'h600, 6'd20, 5'd10);
        expectOp(6'd20, 5'd10, 32'h604, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        driveOp(BR_BEQ, ITYPE_JAL, 32'h0, 32'h0, 32'h610, 32'h0, 1'b1, 32'h610, 6'd21, 5'd11);
        expectOp(6'd21, 5'd11, 32'h614, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        driveOp(BR_BEQ, ITYPE_JAL, 32'h0, 32'h0, 32'h620, 32'h0, 1'b1, 32'h620, 6'd22, 5'd12);
        @(negedge clk);
        checkOutput("full_ready_low", 32'(ready_out), 32'd0);
        checkOutput("full_cdb_req", 32'(cdb_req), 32'd1);
        cdb_grant = 1'b1;
        #1;
        checkOutput("full_ready_with_pop", 32'(ready_out), 32'd1);
        expectOp(6'd22, 5'd12, 32'h624, 1'b0, 32'h0);
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        checkOutput("drain_valid_0", 32'(cdb_valid), 32'd1);
        @(negedge clk);
        checkOutput("drain_valid_1", 32'(cdb_valid), 32'd1);
        @(negedge clk);
        checkOutput("drain_valid_2", 32'(cdb_valid), 32'd1);
        @(negedge clk);
        checkOutput("drain_valid_3", 32'(cdb_valid), 32'd0);
        checkOutput("drain_cdb_req", 32'(cdb_req), 32'd0);
        checkOutput("full_br_count", 32'(br_count), 32'd10);

        // Flush with two entries queued and a mispredicting op on valid_in
        @(posedge clk);
        #1 cdb_grant = 1'b0;
        applyStimulus(BR_BEQ, ITYPE_JAL, 32'h0, 32'h0, 32'h640, 32'h0, 1'b1, 32'h640,
                      6'd23, 5'd13, 32'h644, 1'b0, 32'h0);
        applyStimulus(BR_BEQ, ITYPE_JAL, 32'h0, 32'h0, 32'h650, 32'h0, 1'b1, 32'h650,
                      6'd24, 5'd14, 32'h654, 1'b0, 32'h0);
        driveOp(BR_BNE, ITYPE_BRANCH, 32'h1, 32'h1, 32'h660, 32'h8, 1'b1, 32'h668, 6'd25, 5'd15);
        flush = 1'b1;
        cdb_grant = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid_in = 1'b0;
        clearScoreboard();
        @(negedge clk);
        checkOutput("flush_cdb_req", 32'(cdb_req), 32'd0);
        checkOutput("flush_cdb_valid", 32'(cdb_valid), 32'd0);
        checkOutput("flush_redirect", 32'(redirect_valid), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("flush_br_count", 32'(br_count), 32'd12);
        checkOutput("flush_mispred_count", 32'(mispred_count), 32'd2);

        // Asynchronous reset between edges with entries queued
        @(posedge clk);
        #1 cdb_grant = 1'b0;
        applyStimulus(BR_BEQ, ITYPE_JAL, 32'h0, 32'h0, 32'h700, 32'h0, 1'b1, 32'h700,
                      6'd26, 5'd16, 32'h704, 1'b0, 32'h0);
        applyStimulus(BR_BEQ, ITYPE_JAL, 32'h0, 32'h0, 32'h710, 32'h0, 1'b0, 32'h710,
                      6'd27, 5'd17, 32'h714, 1'b1, 32'h710);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_cdb_req", 32'(cdb_req), 32'd0);
        checkOutput("arst_cdb_valid", 32'(cdb_valid), 32'd0);
        checkOutput("arst_cdb_preg", 32'(cdb_preg), 32'd0);
        checkOutput("arst_cdb_data", cdb_data, 32'd0);
        checkOutput("arst_cdb_rob_id", 32'(cdb_rob_id), 32'd0);
        checkOutput("arst_redirect_valid", 32'(redirect_valid), 32'd0);
        checkOutput("arst_redirect_pc", redirect_pc, 32'd0);
        checkOutput("arst_redirect_rob_id", 32'(redirect_rob_id), 32'd0);
        checkOutput("arst_br_count", 32'(br_count), 32'd0);
        checkOutput("arst_mispred_count", 32'(mispred_count), 32'd0);
        clearScoreboard();
        exp_br  = 0;
        exp_mis = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("arst_rel_ready", 32'(ready_out), 32'd1);
        checkOutput("arst_rel_cdb_req", 32'(cdb_req), 32'd0);
        cdb_grant = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;

        // 17 mispredicting JALs back to back: both counters saturate at all-ones
        for (int i = 0; i < 17; i++) begin
            applyStimulus(BR_BEQ, ITYPE_JAL, 32'h0, 32'h0, 32'h1000 + 32'(i * 4), 32'h0, 1'b0,
                          32'h1000 + 32'(i * 4), 6'(i), 5'(i), 32'h1004 + 32'(i * 4), 1'b1,
                          32'h1000 + 32'(i * 4));
        end
        repeat (4) @(negedge clk);
        checkOutput("sat_br_count", 32'(br_count), 32'(exp_br));
        checkOutput("sat_mispred_count", 32'(mispred_count), 32'(exp_mis));
        checkOutput("sat_br_all_ones", 32'(br_count), 32'd15);
        checkOutput("sb_cdb_drained", 32'(cdb_q.size()), 32'd0);
        checkOutput("sb_redirect_drained", 32'(redir_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
